bram_read_port_arbiter: RTL and testbench

//   Shares the single matrix BRAM read port (addr out, data in, fixed read latency) among
//   NUM_REQ requesters: op selector, op executor, and the UART matrix dumper.

---
 rtl/bram_read_port_arbiter.sv | 111 +++++++++++
 tb/tb_bram_read_port_arbiter.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/bram_read_port_arbiter.sv
// Round-robin arbiter that shares one fixed-latency BRAM read port among NumReq requesters.
// It supports optional bounded lock bursts and returns one-hot tagged read data to each requester.
module bram_read_port_arbiter #(
  parameter int unsigned NumReq    = 3,
  parameter int unsigned AddrWidth = 14,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned RdLatency = 1,
  parameter int unsigned MaxLock   = 64
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [NumReq-1:0]           req_i,
  input  logic [NumReq-1:0]           lock_i,
  input  logic [NumReq*AddrWidth-1:0] req_addr_i,
  output logic [NumReq-1:0]           gnt_o,
  output logic [NumReq-1:0]           rvalid_o,
  output logic [DataWidth-1:0]        rdata_o,
  output logic [AddrWidth-1:0]        bram_rd_addr_o,
  input  logic [DataWidth-1:0]        bram_rd_data_i,
  output logic                        busy_o
);

  localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int unsigned CntW = $clog2(MaxLock + 1);

  logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0] owner_q, owner_d;
  logic            owner_vld_q, owner_vld_d;
  logic [CntW-1:0] lock_cnt_q, lock_cnt_d;

  logic [RdLatency-1:0][NumReq-1:0] tag_q;
  logic [NumReq-1:0]                rvalid_q;
  logic [DataWidth-1:0]             rdata_q;

  logic            hold;
  logic            win_vld;
  logic            gnt_vld;
  logic [IdxW-1:0] win_idx;
  int unsigned     cand;

  always_comb begin
    hold    = owner_vld_q && req_i[owner_q] && (lock_cnt_q < CntW'(MaxLock));
    win_vld = 1'b0;
    win_idx = '0;
    cand    = 0;
    if (hold) begin
      win_vld = 1'b1;
      win_idx = owner_q;
    end else begin
      // First requester found scanning upward from rr_ptr with wrap.
      for (int unsigned k = 0; k < NumReq; k++) begin
        cand = (int'(rr_ptr_q) + k) % NumReq;
        if (!win_vld && req_i[cand]) begin
          win_vld = 1'b1;
          win_idx = IdxW'(cand);
        end
      end
    end
  end

  // Combinational outputs are forced quiet while reset is asserted.
  assign gnt_vld        = win_vld & rst_ni;
  assign gnt_o          = gnt_vld ? (NumReq'(1) << win_idx) : '0;
  assign bram_rd_addr_o = gnt_vld ? req_addr_i[win_idx*AddrWidth +: AddrWidth] : '0;

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    owner_vld_d = 1'b0;
    lock_cnt_d  = '0;
    if (win_vld) begin
      // A hold grant leaves rr_ptr alone so bursts do not skip other requesters.
      if (!hold) begin
        rr_ptr_d = (win_idx == IdxW'(NumReq - 1)) ? '0 : win_idx + IdxW'(1);
      end
      owner_d     = win_idx;
      owner_vld_d = lock_i[win_idx];
      lock_cnt_d  = hold ? lock_cnt_q + CntW'(1) : CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      owner_vld_q <= 1'b0;
      lock_cnt_q  <= '0;
      tag_q       <= '0;
      rvalid_q    <= '0;
      rdata_q     <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      owner_vld_q <= owner_vld_d;
      lock_cnt_q  <= lock_cnt_d;
      tag_q[0]    <= gnt_o;
      for (int unsigned i = 1; i < RdLatency; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
      rvalid_q <= tag_q[RdLatency-1];
      if (|tag_q[RdLatency-1]) begin
        rdata_q <= bram_rd_data_i;
      end
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign busy_o   = (rst_ni & (|req_i)) | (|tag_q) | (|rvalid_q);

endmodule

// File: tb/tb_bram_read_port_arbiter.sv
// Directed vector bench for bram_read_port_arbiter with MaxLock=4 and a one-cycle BRAM model.
module tb_bram_read_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  req = '0;
  logic [2:0]  lock = '0;
  logic [41:0] req_addr;
  logic [2:0]  gnt, rvalid;
  logic [31:0] rdata;
  logic [13:0] bram_rd_addr;
  logic [31:0] bram_rd_data = '0;
  logic        busy;

  int n_vec = 0;
  int n_fail = 0;

  typedef struct {
    logic [2:0]  req;
    logic [2:0]  lock;
    logic [2:0]  gnt;
    logic [13:0] addr;
    logic [2:0]  rv;
    logic [31:0] rd;
    logic        busy;
  } vec_t;

  vec_t tbl[$];

  assign req_addr = {14'h0200, 14'h0123, 14'h0010};

  always #5 clk = ~clk;

  always @(posedge clk) bram_rd_data <= 32'(bram_rd_addr) + 32'h1000;

  bram_read_port_arbiter #(
    .NumReq(3), .AddrWidth(14), .DataWidth(32), .RdLatency(1), .MaxLock(4)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .lock_i(lock), .req_addr_i(req_addr),
    .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata), .bram_rd_addr_o(bram_rd_addr),
    .bram_rd_data_i(bram_rd_data), .busy_o(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [2:0] r, input logic [2:0] l, input logic [2:0] g,
                     input logic [13:0] a, input logic [2:0] v, input logic [31:0] d,
                     input logic b);
    vec_t e;
    e.req = r; e.lock = l; e.gnt = g; e.addr = a; e.rv = v; e.rd = d; e.busy = b;
    tbl.push_back(e);
  endtask

  initial begin
    // Rotation across all three, then idle drain.
    add(3'b111, 3'b000, 3'b001, 14'h0010, 3'b000, 32'h0,    1'b1);
    add(3'b111, 3'b000, 3'b010, 14'h0123, 3'b000, 32'h0,    1'b1);
    add(3'b111, 3'b000, 3'b100, 14'h0200, 3'b001, 32'h1010, 1'b1);
    add(3'b111, 3'b000, 3'b001, 14'h0010, 3'b010, 32'h1123, 1'b1);
    add(3'b111, 3'b000, 3'b010, 14'h0123, 3'b100, 32'h1200, 1'b1);
    add(3'b111, 3'b000, 3'b100, 14'h0200, 3'b001, 32'h1010, 1'b1);
    add(3'b000, 3'b000, 3'b000, 14'h0000, 3'b010, 32'h1123, 1'b1);
    add(3'b000, 3'b000, 3'b000, 14'h0000, 3'b100, 32'h1200, 1'b1);
    // Single request from requester 1.
    add(3'b010, 3'b000, 3'b010, 14'h0123, 3'b000, 32'h1200, 1'b1);
    add(3'b000, 3'b000, 3'b000, 14'h0000, 3'b000, 32'h1200, 1'b1);
    add(3'b000, 3'b000, 3'b000, 14'h0000, 3'b010, 32'h1123, 1'b1);
    // Lock burst on 0 against req 2, bounded at 4 grants.
    add(3'b001, 3'b001, 3'b001, 14'h0010, 3'b000, 32'h1123, 1'b1);
    add(3'b101, 3'b001, 3'b001, 14'h0010, 3'b000, 32'h1123, 1'b1);
    add(3'b101, 3'b001, 3'b001, 14'h0010, 3'b001, 32'h1010, 1'b1);
    add(3'b101, 3'b001, 3'b001, 14'h0010, 3'b001, 32'h1010, 1'b1);
    add(3'b101, 3'b001, 3'b100, 14'h0200, 3'b001, 32'h1010, 1'b1);
    add(3'b101, 3'b001, 3'b001, 14'h0010, 3'b001, 32'h1010, 1'b1);
    add(3'b101, 3'b001, 3'b001, 14'h0010, 3'b100, 32'h1200, 1'b1);
    add(3'b000, 3'b000, 3'b000, 14'h0000, 3'b001, 32'h1010, 1'b1);
    add(3'b000, 3'b000, 3'b000, 14'h0000, 3'b001, 32'h1010, 1'b1);
    add(3'b000, 3'b000, 3'b000, 14'h0000, 3'b000, 32'h1010, 1'b0);
    // Locked owner 1 drops req; requester 0 served with no idle cycle.
    add(3'b010, 3'b010, 3'b010, 14'h0123, 3'b000, 32'h1010, 1'b1);
    add(3'b011, 3'b010, 3'b010, 14'h0123, 3'b000, 32'h1010, 1'b1);
    add(3'b001, 3'b000, 3'b001, 14'h0010, 3'b010, 32'h1123, 1'b1);
    add(3'b000, 3'b000, 3'b000, 14'h0000, 3'b010, 32'h1123, 1'b1);
    add(3'b000, 3'b000, 3'b000, 14'h0000, 3'b001, 32'h1010, 1'b1);
    add(3'b000, 3'b000, 3'b000, 14'h0000, 3'b000, 32'h1010, 1'b0);

    // Reset with all requests high.
    req = 3'b111;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_addr", 32'(bram_rd_addr), 32'h0);
    chk("rst_rvalid", 32'(rvalid), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      req  = tbl[i].req;
      lock = tbl[i].lock;
      @(negedge clk);
      chk($sformatf("v%0d_gnt", i), 32'(gnt), 32'(tbl[i].gnt));
      chk($sformatf("v%0d_addr", i), 32'(bram_rd_addr), 32'(tbl[i].addr));
      chk($sformatf("v%0d_rvalid", i), 32'(rvalid), 32'(tbl[i].rv));
      chk($sformatf("v%0d_rdata", i), rdata, tbl[i].rd);
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
      @(posedge clk);
      #1;
    end

    // Reset one cycle after a grant: the in-flight read never returns.
    req = 3'b100;
    @(negedge clk);
    chk("mid_gnt", 32'(gnt), 32'h4);
    @(posedge clk);
    #1 req = 3'b000;
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_rvalid", 32'(rvalid), 32'h0);
    chk("mid_rst_rdata", rdata, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("post_rst%0d_rvalid", i), 32'(rvalid), 32'h0);
      chk($sformatf("post_rst%0d_busy", i), 32'(busy), 32'h0);
      chk($sformatf("post_rst%0d_rdata", i), rdata, 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
